// File: rtl/cpu_pkg.sv
// Shared core definitions: reset PC, NOP encoding and the (pc, instr) pair
// carried from IF to ID.
package cpu_pkg;

    localparam logic [31:0] PC_INIT   = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_perf.sv
// Fetch-queue performance counters: PC stall cycles and flush events.
// Both saturate at all-ones. Instantiated only when FETCH_QUEUE_PERF_EN is defined.
module fetch_queue_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        update_en,
    input  logic        flush,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!update_en && (stall_q != '1))
            stall_d = stall_q + 32'd1;
        if (flush && (flush_q != '1))
            flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: rtl/fetch_queue.sv
// IF->ID decoupling queue: circular buffer of (pc, instr) pairs, PC update enable
// and flush. Optional perf counters under FETCH_QUEUE_PERF_EN.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              instr_in,
    input  logic                     flush,
    output logic                     update_en,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_instr,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]              stall_cycles,
    output logic [15:0]              flush_count,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (PC_RESET[1:0] != 2'b00)) begin : g_bad_cfg
        $error("fetch_queue: DEPTH must be a power of two >= 2 and PC_RESET word aligned");
    end

    fetch_pair_t       mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // update_en deliberately ignores id_ready so the PC enable never waits on ID.
    assign update_en = !full || flush;
    assign push      = !full && !flush;
    assign pop       = id_valid && id_ready && !flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push)
                wptr_d = wptr_q + PW'(1);
            if (pop)
                rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= '{pc: pc_in, instr: instr_in};
    end

    assign id_valid = !empty;
    assign id_pc    = empty ? 32'h0     : mem_q[rptr_q].pc;
    assign id_instr = empty ? NOP_INSTR : mem_q[rptr_q].instr;
    assign count    = count_q;

`ifdef FETCH_QUEUE_PERF_EN
    fetch_queue_perf u_perf (
        .clk          (clk),
        .reset        (reset),
        .update_en    (update_en),
        .flush        (flush),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`endif

endmodule
